// File: rtl/pipe_mem_arbiter_pkg.sv
// Shared encodings for the IF/MEM memory arbiter and the control decode.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
    typedef enum logic {OWN_IF, OWN_DM} arb_owner_t;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;
endpackage

// File: rtl/pipe_mem_arbiter_lat_timer.sv
// Loadable down-counter timing the memory read latency; done while the count is zero.
module mem_arb_lat_timer #(
    parameter  int MEM_LAT = 1,
    localparam int CW      = $clog2(MEM_LAT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] value,
    output logic          done
);
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= value;
        else if (count != '0)
            count <= count - CW'(1);
    end

    assign done = (count == '0);
endmodule

// File: rtl/pipe_mem_arbiter.sv
// Shares one single-port memory between the IF fetch port and the MEM data port,
// one access at a time, stalling the pipeline until each request is acknowledged.
module pipe_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [2:0]        dm_type,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              pipe_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [2:0]        mem_type,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(STARVE_MAX + 2);

    arb_state_t    state, state_nx;
    arb_owner_t    owner;
    logic          drop;
    logic          store;
    logic [SW-1:0] streak;
    logic          lat_done, lat_load;
    logic          if_vld, contended, pick_if, arb_go;

    // A killed fetch never competes for the memory.
    assign if_vld    = if_req & ~if_kill;
    assign contended = if_vld & dm_req;
    assign pick_if   = if_vld & (~dm_req | (streak == SW'(STARVE_MAX)));
    assign arb_go    = (state == IDLE) & (if_vld | dm_req);
    assign lat_load  = (state == ISSUE);

    assign if_ack     = (state == RESP) & (owner == OWN_IF) & ~drop & ~if_kill;
    assign dm_ack     = (state == RESP) & (owner == OWN_DM);
    assign pipe_stall = (if_req & ~if_ack) | (dm_req & ~dm_ack);

    mem_arb_lat_timer #(.MEM_LAT(MEM_LAT)) u_lat (
        .clk   (clk),
        .reset (reset),
        .load  (lat_load),
        .value (CW'(MEM_LAT - 1)),
        .done  (lat_done)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (arb_go) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (lat_done) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            drop      <= 1'b0;
            store     <= 1'b0;
            streak    <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_type  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            state  <= state_nx;
            mem_en <= arb_go;
            mem_we <= arb_go & ~pick_if & dm_we;
            if (arb_go) begin
                owner     <= pick_if ? OWN_IF : OWN_DM;
                store     <= ~pick_if & dm_we;
                mem_addr  <= pick_if ? if_addr : dm_addr;
                mem_type  <= pick_if ? DM_WORD : dm_type;
                mem_wdata <= pick_if ? '0 : dm_wdata;
            end
            if (state == IDLE)
                drop <= 1'b0;
            else if (owner == OWN_IF && if_kill)
                drop <= 1'b1;
            // Streak only counts DM wins over a live fetch; any quiet IF cycle forgives it.
            if (state == IDLE) begin
                if (arb_go && pick_if)
                    streak <= '0;
                else if (contended)
                    streak <= (streak == SW'(STARVE_MAX)) ? streak : streak + SW'(1);
                else if (!if_req)
                    streak <= '0;
            end
            if (state == WAIT && lat_done) begin
                if (owner == OWN_IF && !drop && !if_kill)
                    if_rdata <= mem_rdata;
                if (owner == OWN_DM && !store)
                    dm_rdata <= mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Bench for pipe_mem_arbiter: directed scenarios plus random traffic checked by a transaction-timed model.
module tb_pipe_mem_arbiter;
    import mem_arb_pkg::*;
    localparam int MEM_LAT    = 1;
    localparam int STARVE_MAX = 3;

    logic        clk = 1'b0, reset = 1'b1;
    logic        if_req = 0, if_kill = 0, dm_req = 0, dm_we = 0;
    logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0;
    logic [2:0]  dm_type = 0;
    logic        if_ack, dm_ack, pipe_stall, mem_en, mem_we;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_type;

    int total = 0, bad = 0;
    logic [31:0] grant_q[$];

    always #5 clk = ~clk;

    pipe_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_ack(if_ack), .if_rdata(if_rdata), .dm_req(dm_req), .dm_we(dm_we), .dm_type(dm_type),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .pipe_stall(pipe_stall), .mem_en(mem_en), .mem_we(mem_we), .mem_type(mem_type),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a == 32'h40) ? 32'h00500093 : ((a * 32'h9E3779B1) ^ 32'h5A5A0F0F);
    endfunction

    // Memory environment: reads return data MEM_LAT cycles after the strobe, poison otherwise.
    logic [31:0] env_mem [1024];
    bit          env_vld [1024];
    logic [31:0] rd_sh [MEM_LAT];
    function automatic logic [31:0] env_rd(input logic [31:0] a);
        return env_vld[a[11:2]] ? env_mem[a[11:2]] : dflt(a);
    endfunction
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            env_mem[mem_addr[11:2]] <= mem_wdata;
            env_vld[mem_addr[11:2]] <= 1'b1;
        end
        rd_sh[0] <= (mem_en && !mem_we) ? env_rd(mem_addr) : 32'hBAD0BAD0;
        for (int i = 1; i < MEM_LAT; i++) rd_sh[i] <= rd_sh[i-1];
    end
    assign mem_rdata = rd_sh[MEM_LAT-1];

    // Reference model: one access at a time, timed from the arbitration cycle by arithmetic.
    int          k = 0, busy_end = -1, m_issue = -1, m_streak = 0;
    bit          m_if, m_we, m_drop;
    logic [31:0] m_addr, m_wdata, m_val, e_if_rd = 0, e_dm_rd = 0;
    logic [2:0]  m_type;
    logic [31:0] ref_mem [1024];
    bit          ref_vld [1024];

    initial forever begin
        @(negedge clk);
        k++;
        begin : model
            bit busy, kill_now, e_en, e_ia, e_da, ifv, pick;
            busy     = (k <= busy_end);
            kill_now = busy && m_if && if_kill;
            e_en     = busy && (k == m_issue);
            e_ia     = busy && (k == busy_end) && m_if && !(m_drop || kill_now);
            e_da     = busy && (k == busy_end) && !m_if;
            chk("mem_en", 32'(mem_en), 32'(e_en));
            if (e_en) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_we", 32'(mem_we), 32'(m_we));
                if (!m_if) chk("mem_type", 32'(mem_type), 32'(m_type));
                if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
            end
            chk("if_ack", 32'(if_ack), 32'(e_ia));
            chk("dm_ack", 32'(dm_ack), 32'(e_da));
            chk("pipe_stall", 32'(pipe_stall), 32'((if_req && !e_ia) || (dm_req && !e_da)));
            chk("if_rdata", if_rdata, e_if_rd);
            chk("dm_rdata", dm_rdata, e_dm_rd);
            if (mem_en) grant_q.push_back(mem_addr);
            if (reset) begin
                busy_end = -1; m_issue = -1; m_streak = 0; m_drop = 0;
                e_if_rd = 0; e_dm_rd = 0;
            end else if (busy) begin
                if (kill_now) m_drop = 1;
                if (k == m_issue && m_we) begin
                    ref_mem[m_addr[11:2]] = m_wdata;
                    ref_vld[m_addr[11:2]] = 1;
                end
                if (k == busy_end - 1) begin
                    if (m_if && !m_drop) e_if_rd = m_val;
                    if (!m_if && !m_we) e_dm_rd = m_val;
                end
            end else begin
                ifv = if_req && !if_kill;
                if (ifv || dm_req) begin
                    pick = ifv && (!dm_req || m_streak == STARVE_MAX);
                    if (pick) m_streak = 0;
                    else if (ifv) m_streak = (m_streak < STARVE_MAX) ? m_streak + 1 : m_streak;
                    else if (!if_req) m_streak = 0;
                    m_if = pick; m_we = !pick && dm_we;
                    m_addr = pick ? if_addr : dm_addr;
                    m_type = dm_type; m_wdata = dm_wdata;
                    m_val = ref_vld[m_addr[11:2]] ? ref_mem[m_addr[11:2]] : dflt(m_addr);
                    m_issue = k + 1; busy_end = k + 2 + MEM_LAT; m_drop = 0;
                end else if (!if_req) m_streak = 0;
            end
        end
    end

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic smp(); @(negedge clk); endtask
    task automatic idle(input int n);
        repeat (n) begin tick(); if_req = 0; dm_req = 0; if_kill = 0; end
    endtask
    task automatic dm_load(input logic [31:0] a);
        dm_req = 1; dm_we = 0; dm_type = DM_WORD; dm_addr = a;
    endtask
    task automatic new_dm();
        dm_we = ($urandom_range(0, 2) == 0); dm_type = 3'($urandom_range(0, 4));
        dm_addr = 32'h200 + ($urandom_range(0, 15) << 2); dm_wdata = $urandom;
    endtask
    function automatic logic [31:0] rnd_if();
        return 32'h400 + ($urandom_range(0, 255) << 2);
    endfunction

    logic [31:0] prev, s_exp [6];
    bit ia, da, ka, done;
    int nd, n_en;

    initial begin
        repeat (3) tick();
        reset = 0;
        smp();
        chk("rst_if_ack", 32'(if_ack), 0);    chk("rst_dm_ack", 32'(dm_ack), 0);
        chk("rst_mem_en", 32'(mem_en), 0);    chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", mem_addr, 0);     chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);     chk("rst_stall", 32'(pipe_stall), 0);

        // lone fetch
        idle(2);
        if_req = 1; if_addr = 32'h40;
        smp(); chk("f_stall0", 32'(pipe_stall), 1); chk("f_en0", 32'(mem_en), 0);
        tick(); smp(); chk("f_en1", 32'(mem_en), 1); chk("f_addr1", mem_addr, 32'h40);
        chk("f_stall1", 32'(pipe_stall), 1);
        tick(); smp(); chk("f_ack2", 32'(if_ack), 0); chk("f_stall2", 32'(pipe_stall), 1);
        tick(); smp(); chk("f_ack3", 32'(if_ack), 1); chk("f_rdata", if_rdata, 32'h00500093);
        chk("f_stall3", 32'(pipe_stall), 0);

        // contention
        idle(3); grant_q.delete(); done = 0;
        if_req = 1; if_addr = 32'h44; dm_load(32'h100);
        for (int n = 0; n < 20 && !done; n++) begin
            smp();
            if (if_ack) begin chk("c_stall_end", 32'(pipe_stall), 0); done = 1; end
            else chk("c_stall", 32'(pipe_stall), 1);
            da = dm_ack;
            tick();
            if (da) dm_req = 0;
            if (done) if_req = 0;
        end
        if (!done) chk("c_timeout", 0, 1);
        chk("c_n", 32'(grant_q.size()), 2);
        if (grant_q.size() >= 2) begin chk("c_g0", grant_q[0], 32'h100); chk("c_g1", grant_q[1], 32'h44); end

        // starvation
        idle(3); grant_q.delete(); nd = 0;
        s_exp = '{32'h300, 32'h304, 32'h308, 32'h80, 32'h30C, 32'h310};
        if_req = 1; if_addr = 32'h80; dm_load(32'h300);
        for (int n = 0; n < 100 && (if_req || dm_req); n++) begin
            smp(); ia = if_ack; da = dm_ack;
            tick();
            if (ia) if_req = 0;
            if (da) begin nd++; if (nd == 5) dm_req = 0; else dm_addr = 32'h300 + 32'(nd * 4); end
        end
        if (if_req || dm_req) chk("s_timeout", 0, 1);
        chk("s_n", 32'(grant_q.size()), 6);
        for (int i = 0; i < 6; i++)
            if (i < grant_q.size()) chk($sformatf("s_g%0d", i), grant_q[i], s_exp[i]);

        // store
        idle(3); prev = dm_rdata; n_en = 0;
        dm_req = 1; dm_we = 1; dm_type = DM_WORD; dm_addr = 32'h20; dm_wdata = 32'hDEADBEEF;
        for (int n = 0; n <= 3; n++) begin
            smp();
            if (mem_en) begin
                n_en++;
                chk("st_we", 32'(mem_we), 1); chk("st_addr", mem_addr, 32'h20);
                chk("st_wdata", mem_wdata, 32'hDEADBEEF); chk("st_type", 32'(mem_type), 32'(DM_WORD));
            end
            chk($sformatf("st_ack%0d", n), 32'(dm_ack), 32'(n == 3));
            if (n < 3) tick();
        end
        chk("st_rdata", dm_rdata, prev);
        chk("st_n_en", 32'(n_en), 1);

        // kill during WAIT
        idle(3); prev = if_rdata; ka = 0;
        if_req = 1; if_addr = 32'h48;
        smp(); tick();
        smp(); tick(); if_kill = 1;
        smp(); ka |= if_ack; tick(); if_kill = 0; if_req = 0;
        smp(); ka |= if_ack; tick(); dm_load(32'h104);
        smp(); ka |= if_ack; tick();
        smp(); chk("k_en", 32'(mem_en), 1); chk("k_addr", mem_addr, 32'h104);
        chk("k_ack", 32'(ka), 0); chk("k_rdata", if_rdata, prev);
        done = 0;
        for (int n = 0; n < 20 && !done; n++) begin
            if (dm_ack) done = 1;
            tick();
            if (done) dm_req = 0; else smp();
        end
        if (!done) chk("k_timeout", 0, 1);

        // reset in WAIT
        idle(3);
        dm_load(32'h108);
        tick();
        tick(); reset = 1;
        tick(); reset = 0; dm_req = 0;
        smp(); chk("r_dm_ack", 32'(dm_ack), 0); chk("r_if_ack", 32'(if_ack), 0);
        chk("r_en", 32'(mem_en), 0); chk("r_dm_rdata", dm_rdata, 0);
        ka = 0;
        repeat (4) begin tick(); smp(); ka |= dm_ack; end
        chk("r_noack", 32'(ka), 0);

        // random traffic against the model
        idle(2);
        for (int n = 0; n < 3000; n++) begin
            smp(); ia = if_ack; da = dm_ack;
            tick();
            if (if_kill) begin
                if_kill = 0; if_req = ($urandom_range(0, 1) == 1); if_addr = rnd_if();
            end else if (!if_req || ia) begin
                if_req = ($urandom_range(0, 2) != 0); if_addr = rnd_if();
            end
            if (if_req && $urandom_range(0, 19) == 0) if_kill = 1;
            if (!dm_req || da) begin dm_req = ($urandom_range(0, 2) != 0); new_dm(); end
        end
        idle(8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
